// File: rtl/axi_lite_arbiter_pkg.sv
// Shared definitions for the two-master AXI-Lite arbiter: FSM encodings,
// response codes and the two-way round-robin pick.
package axi_lite_arbiter_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Contention goes to the pointer's master; a lone requester always wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
        return (req[0] && req[1]) ? ptr : req[1];
    endfunction

endpackage

// File: rtl/axi_lite_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: latches the winner while the owning FSM
// is idle and hands priority to the other master when the transaction ends.
module rr_arb2
    import axi_lite_arbiter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_arb,
    input  logic       i_done,
    output logic       o_grant
);

    logic r_grant;
    logic r_ptr;
    logic w_pick;

    always_comb begin
        w_pick = rr_pick(i_req, r_ptr);
    end

    // Pointer moves only on completion, never on the arbitration itself.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant <= 1'b0;
            r_ptr   <= 1'b0;
        end else begin
            if (i_arb && (|i_req)) begin
                r_grant <= w_pick;
            end
            if (i_done) begin
                r_ptr <= ~r_grant;
            end
        end
    end

    assign o_grant = r_grant;

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI-Lite arbiter with independent write and read
// paths, each owned by one master at a time under round-robin priority.
module axi_lite_arbiter
    import axi_lite_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_axi_clk,
    input  logic                  i_axi_rst,

    input  logic                  i_m0_awvalid,
    input  logic [ADDR_WIDTH-1:0] i_m0_awaddr,
    output logic                  o_m0_awready,
    input  logic                  i_m0_wvalid,
    input  logic [DATA_WIDTH-1:0] i_m0_wdata,
    output logic                  o_m0_wready,
    output logic                  o_m0_bvalid,
    output logic [1:0]            o_m0_bresp,
    input  logic                  i_m0_bready,
    input  logic                  i_m0_arvalid,
    input  logic [ADDR_WIDTH-1:0] i_m0_araddr,
    output logic                  o_m0_arready,
    output logic                  o_m0_rvalid,
    output logic [1:0]            o_m0_rresp,
    output logic [DATA_WIDTH-1:0] o_m0_rdata,
    input  logic                  i_m0_rready,

    input  logic                  i_m1_awvalid,
    input  logic [ADDR_WIDTH-1:0] i_m1_awaddr,
    output logic                  o_m1_awready,
    input  logic                  i_m1_wvalid,
    input  logic [DATA_WIDTH-1:0] i_m1_wdata,
    output logic                  o_m1_wready,
    output logic                  o_m1_bvalid,
    output logic [1:0]            o_m1_bresp,
    input  logic                  i_m1_bready,
    input  logic                  i_m1_arvalid,
    input  logic [ADDR_WIDTH-1:0] i_m1_araddr,
    output logic                  o_m1_arready,
    output logic                  o_m1_rvalid,
    output logic [1:0]            o_m1_rresp,
    output logic [DATA_WIDTH-1:0] o_m1_rdata,
    input  logic                  i_m1_rready,

    output logic                  o_s_awvalid,
    output logic [ADDR_WIDTH-1:0] o_s_awaddr,
    input  logic                  i_s_awready,
    output logic                  o_s_wvalid,
    output logic [DATA_WIDTH-1:0] o_s_wdata,
    input  logic                  i_s_wready,
    input  logic                  i_s_bvalid,
    input  logic [1:0]            i_s_bresp,
    output logic                  o_s_bready,
    output logic                  o_s_arvalid,
    output logic [ADDR_WIDTH-1:0] o_s_araddr,
    input  logic                  i_s_arready,
    input  logic                  i_s_rvalid,
    input  logic [1:0]            i_s_rresp,
    input  logic [DATA_WIDTH-1:0] i_s_rdata,
    output logic                  o_s_rready,

    output logic                  o_wgrant,
    output logic                  o_rgrant
);

    wr_state_t r_wstate;
    wr_state_t w_wstate_nxt;
    rd_state_t r_rstate;
    rd_state_t w_rstate_nxt;

    logic w_wgrant;
    logic w_rgrant;
    logic w_sel_awvalid;
    logic w_sel_wvalid;
    logic w_sel_bready;
    logic w_sel_arvalid;
    logic w_sel_rready;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;

    rr_arb2 u_wr_arb (
        .i_clk   (i_axi_clk),
        .i_rst_n (i_axi_rst),
        .i_req   ({i_m1_awvalid, i_m0_awvalid}),
        .i_arb   (r_wstate == W_IDLE),
        .i_done  (w_b_hs),
        .o_grant (w_wgrant)
    );

    rr_arb2 u_rd_arb (
        .i_clk   (i_axi_clk),
        .i_rst_n (i_axi_rst),
        .i_req   ({i_m1_arvalid, i_m0_arvalid}),
        .i_arb   (r_rstate == R_IDLE),
        .i_done  (w_r_hs),
        .o_grant (w_rgrant)
    );

    assign o_wgrant = w_wgrant;
    assign o_rgrant = w_rgrant;

    assign w_sel_awvalid = w_wgrant ? i_m1_awvalid : i_m0_awvalid;
    assign w_sel_wvalid  = w_wgrant ? i_m1_wvalid  : i_m0_wvalid;
    assign w_sel_bready  = w_wgrant ? i_m1_bready  : i_m0_bready;
    assign w_sel_arvalid = w_rgrant ? i_m1_arvalid : i_m0_arvalid;
    assign w_sel_rready  = w_rgrant ? i_m1_rready  : i_m0_rready;

    assign o_s_awaddr = w_wgrant ? i_m1_awaddr : i_m0_awaddr;
    assign o_s_wdata  = w_wgrant ? i_m1_wdata  : i_m0_wdata;
    assign o_s_araddr = w_rgrant ? i_m1_araddr : i_m0_araddr;

    assign w_aw_hs = (r_wstate == W_ADDR) && w_sel_awvalid && i_s_awready;
    assign w_w_hs  = (r_wstate == W_DATA) && w_sel_wvalid  && i_s_wready;
    assign w_b_hs  = (r_wstate == W_RESP) && i_s_bvalid    && w_sel_bready;
    assign w_ar_hs = (r_rstate == R_ADDR) && w_sel_arvalid && i_s_arready;
    assign w_r_hs  = (r_rstate == R_DATA) && i_s_rvalid    && w_sel_rready;

    // Write path
    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (i_m0_awvalid || i_m1_awvalid) w_wstate_nxt = W_ADDR;
            W_ADDR:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs)  w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs)  w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        o_s_awvalid  = 1'b0;
        o_s_wvalid   = 1'b0;
        o_s_bready   = 1'b0;
        o_m0_awready = 1'b0;
        o_m1_awready = 1'b0;
        o_m0_wready  = 1'b0;
        o_m1_wready  = 1'b0;
        o_m0_bvalid  = 1'b0;
        o_m1_bvalid  = 1'b0;
        o_m0_bresp   = RESP_OKAY;
        o_m1_bresp   = RESP_OKAY;
        case (r_wstate)
            W_ADDR: begin
                o_s_awvalid  = w_sel_awvalid;
                o_m0_awready = !w_wgrant && i_s_awready;
                o_m1_awready =  w_wgrant && i_s_awready;
            end
            W_DATA: begin
                o_s_wvalid  = w_sel_wvalid;
                o_m0_wready = !w_wgrant && i_s_wready;
                o_m1_wready =  w_wgrant && i_s_wready;
            end
            W_RESP: begin
                o_s_bready = w_sel_bready;
                if (w_wgrant) begin
                    o_m1_bvalid = i_s_bvalid;
                    o_m1_bresp  = i_s_bresp;
                end else begin
                    o_m0_bvalid = i_s_bvalid;
                    o_m0_bresp  = i_s_bresp;
                end
            end
            default: ;
        endcase
    end

    // Read path
    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (i_m0_arvalid || i_m1_arvalid) w_rstate_nxt = R_ADDR;
            R_ADDR:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs)  w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        o_s_arvalid  = 1'b0;
        o_s_rready   = 1'b0;
        o_m0_arready = 1'b0;
        o_m1_arready = 1'b0;
        o_m0_rvalid  = 1'b0;
        o_m1_rvalid  = 1'b0;
        o_m0_rresp   = RESP_OKAY;
        o_m1_rresp   = RESP_OKAY;
        o_m0_rdata   = '0;
        o_m1_rdata   = '0;
        case (r_rstate)
            R_ADDR: begin
                o_s_arvalid  = w_sel_arvalid;
                o_m0_arready = !w_rgrant && i_s_arready;
                o_m1_arready =  w_rgrant && i_s_arready;
            end
            R_DATA: begin
                o_s_rready = w_sel_rready;
                if (w_rgrant) begin
                    o_m1_rvalid = i_s_rvalid;
                    o_m1_rresp  = i_s_rresp;
                    o_m1_rdata  = i_s_rdata;
                end else begin
                    o_m0_rvalid = i_s_rvalid;
                    o_m0_rresp  = i_s_rresp;
                    o_m0_rdata  = i_s_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule
